// File: rtl/trap_filter_peak.sv
// Trapezoidal shaping filter (K/L/M deconvolution form) with a peak-capture FSM.
// Samples flow through a K+L delay line, a second-difference stage, two
// accumulators and a saturating output stage. The FSM watches the registered
// output, tracks the first maximum of each pulse above threshold and reports it
// through a valid/ready handshake.
module trap_filter_peak #(
    parameter int SIZE_ADC_DATA    = 14,
    parameter int SIZE_FILTER_DATA = 24,
    parameter int K                = 2,
    parameter int L                = 4,
    parameter int M                = 0,
    parameter int SHIFT            = 0,
    parameter int ACC_W            = 48,
    parameter int TS_W             = 32
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        clear,
    input  logic                        bypass,
    input  logic [SIZE_ADC_DATA-1:0]    input_data,
    input  logic [SIZE_FILTER_DATA-1:0] threshold,
    output logic [SIZE_FILTER_DATA-1:0] filter_out,
    output logic                        peak_valid,
    input  logic                        peak_ready,
    output logic [SIZE_FILTER_DATA-1:0] peak_amp,
    output logic [TS_W-1:0]             peak_ts,
    output logic [7:0]                  lost_cnt
);

    localparam int N  = K + L;
    localparam int DW = SIZE_ADC_DATA + 2;
    localparam int FW = SIZE_FILTER_DATA;

    localparam logic signed [ACC_W-1:0] M_S   = ACC_W'(M);
    localparam logic signed [ACC_W-1:0] MAX_V = {{(ACC_W-FW+1){1'b0}}, {(FW-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] MIN_V = {{(ACC_W-FW+1){1'b1}}, {(FW-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, ABOVE, REPORT} state_t;

    logic [SIZE_ADC_DATA-1:0] delay_line [N];
    logic [SIZE_ADC_DATA-1:0] byp1, byp2;
    logic signed [DW-1:0]     d, d_next;
    logic signed [ACC_W-1:0]  p, r, s;
    logic signed [ACC_W-1:0]  d_ext, p_next, r_next, stage3;
    logic [FW-1:0]            sat_out;

    state_t                   state, state_next;
    logic [TS_W-1:0]          ts;
    logic [FW-1:0]            max_amp;
    logic [TS_W-1:0]          max_ts;
    logic                     above, prev_above;
    logic                     load_max, latch_report, hand_done, lose;

    // Second difference, accumulator inputs and the saturating output select.
    always_comb begin
        d_next = $signed({2'b00, input_data})
               - $signed({2'b00, delay_line[K-1]})
               - $signed({2'b00, delay_line[L-1]})
               + $signed({2'b00, delay_line[N-1]});
        d_ext  = {{(ACC_W-DW){d[DW-1]}}, d};
        p_next = p + d_ext;
        r_next = p_next + M_S * d_ext;
        stage3 = bypass ? {{(ACC_W-SIZE_ADC_DATA){1'b0}}, byp2} : (s >>> SHIFT);
        if (stage3 > MAX_V)
            sat_out = MAX_V[FW-1:0];
        else if (stage3 < MIN_V)
            sat_out = MIN_V[FW-1:0];
        else
            sat_out = stage3[FW-1:0];
    end

    // Filter pipeline: delay line, d, p/r, s and the output register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N; i++) delay_line[i] <= '0;
            d          <= '0;
            p          <= '0;
            r          <= '0;
            s          <= '0;
            byp1       <= '0;
            byp2       <= '0;
            filter_out <= '0;
        end else if (clear) begin
            for (int i = 0; i < N; i++) delay_line[i] <= '0;
            d          <= '0;
            p          <= '0;
            r          <= '0;
            s          <= '0;
            byp1       <= '0;
            byp2       <= '0;
            filter_out <= '0;
        end else begin
            delay_line[0] <= input_data;
            for (int i = 1; i < N; i++) delay_line[i] <= delay_line[i-1];
            d          <= d_next;
            p          <= p_next;
            r          <= r_next;
            s          <= s + r;
            byp1       <= delay_line[0];
            byp2       <= byp1;
            filter_out <= sat_out;
        end
    end

    // Free-running timestamp; survives clear so reports stay on one time base.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            ts <= '0;
        else
            ts <= ts + TS_W'(1);
    end

    // Peak FSM next-state logic and the strobes that drive the report registers.
    always_comb begin
        above        = $signed(filter_out) > $signed(threshold);
        state_next   = state;
        load_max     = 1'b0;
        latch_report = 1'b0;
        hand_done    = 1'b0;
        lose         = 1'b0;
        case (state)
            IDLE: begin
                if (above) begin
                    state_next = ABOVE;
                    load_max   = 1'b1;
                end
            end
            ABOVE: begin
                if (above) begin
                    if ($signed(filter_out) > $signed(max_amp)) load_max = 1'b1;
                end else begin
                    state_next   = REPORT;
                    latch_report = 1'b1;
                end
            end
            REPORT: begin
                if (peak_ready) begin
                    hand_done = 1'b1;
                    if (above) begin
                        state_next = ABOVE;
                        load_max   = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end else if (above && !prev_above) begin
                    lose = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // FSM state register; clear forces the idle state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= IDLE;
        else if (clear)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Running maximum, report registers and dropped-peak counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            max_amp    <= '0;
            max_ts     <= '0;
            peak_amp   <= '0;
            peak_ts    <= '0;
            peak_valid <= 1'b0;
            prev_above <= 1'b0;
            lost_cnt   <= '0;
        end else if (clear) begin
            peak_valid <= 1'b0;
            prev_above <= 1'b0;
        end else begin
            prev_above <= above;
            if (load_max) begin
                max_amp <= filter_out;
                max_ts  <= ts;
            end
            if (latch_report) begin
                peak_amp   <= max_amp;
                peak_ts    <= max_ts;
                peak_valid <= 1'b1;
            end
            if (hand_done) peak_valid <= 1'b0;
            if (lose && lost_cnt != 8'hFF) lost_cnt <= lost_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_trap_filter_peak.sv
// Self-checking bench for trap_filter_peak: three instances (M=0, M=1, and a
// narrow 12-bit output) share one stimulus stream and are compared against a
// sample-history reference model after every clock.
module tb_trap_filter_peak;

    localparam int AW = 14;
    localparam int K  = 2;
    localparam int L  = 4;
    localparam int N  = K + L;

    logic        clk = 1'b0;
    logic        reset, clear, bypass, peak_ready;
    logic [13:0] input_data;
    logic [23:0] threshold;

    logic [23:0] fo0, pa0, fo1, pa1;
    logic [11:0] fo2, pa2;
    logic        pv0, pv1, pv2;
    logic [31:0] pts0, pts1, pts2;
    logic [7:0]  lc0, lc1, lc2;

    trap_filter_peak #(.SIZE_ADC_DATA(AW), .SIZE_FILTER_DATA(24), .K(K), .L(L), .M(0)) dut (
        .clk(clk), .reset(reset), .clear(clear), .bypass(bypass), .input_data(input_data),
        .threshold(threshold), .filter_out(fo0), .peak_valid(pv0), .peak_ready(peak_ready),
        .peak_amp(pa0), .peak_ts(pts0), .lost_cnt(lc0));

    trap_filter_peak #(.SIZE_ADC_DATA(AW), .SIZE_FILTER_DATA(24), .K(K), .L(L), .M(1)) dut_m1 (
        .clk(clk), .reset(reset), .clear(clear), .bypass(bypass), .input_data(input_data),
        .threshold(threshold), .filter_out(fo1), .peak_valid(pv1), .peak_ready(peak_ready),
        .peak_amp(pa1), .peak_ts(pts1), .lost_cnt(lc1));

    trap_filter_peak #(.SIZE_ADC_DATA(AW), .SIZE_FILTER_DATA(12), .K(K), .L(L), .M(0)) dut_sat (
        .clk(clk), .reset(reset), .clear(clear), .bypass(bypass), .input_data(input_data),
        .threshold(threshold[11:0]), .filter_out(fo2), .peak_valid(pv2), .peak_ready(peak_ready),
        .peak_amp(pa2), .peak_ts(pts2), .lost_cnt(lc2));

    // 10-unit clock period.
    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    int          hx [N];
    longint      mp;
    longint      ms [3];
    longint      qf [3][3];
    longint      qx [3];
    longint      mfo [3];
    longint      mW [3] = '{24, 24, 12};
    longint      mM [3] = '{0, 1, 0};
    bit          mtrack, mvalid, mprev;
    longint      mmax, mamp;
    logic [31:0] mts, mmts, mpts;
    int          mlost;

    typedef struct {
        logic [13:0] x;
        longint      e0;
        longint      e1;
    } vec_t;

    vec_t tbl [12];

    task automatic checkOutput(input string name, input longint act, input longint exp);
        checks++;
        if (act == exp) passed++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    function automatic longint sat(input longint v, input longint w);
        longint hi;
        hi = (longint'(1) <<< (w - 1)) - 1;
        if (v > hi) return hi;
        if (v < -hi - 1) return -hi - 1;
        return v;
    endfunction

    task automatic modelReset();
        for (int i = 0; i < N; i++) hx[i] = 0;
        mp = 0;
        for (int i = 0; i < 3; i++) begin
            ms[i] = 0;
            mfo[i] = 0;
            qx[i] = 0;
            for (int j = 0; j < 3; j++) qf[i][j] = 0;
        end
        mtrack = 0; mvalid = 0; mprev = 0;
        mmax = 0; mamp = 0; mts = 0; mmts = 0; mpts = 0; mlost = 0;
    endtask

    // Advance the reference model by one clock using the currently applied inputs.
    task automatic modelEdge();
        longint thr, d, x, xo, ff;
        bit     above;
        thr = longint'($signed(threshold));
        if (clear) begin
            mtrack = 0; mvalid = 0; mprev = 0;
        end else begin
            above = mfo[0] > thr;
            if (mvalid) begin
                if (peak_ready) begin
                    mvalid = 0;
                    mtrack = above;
                    if (above) begin mmax = mfo[0]; mmts = mts; end
                end else if (above && !mprev && mlost < 255) begin
                    mlost++;
                end
            end else if (mtrack) begin
                if (above) begin
                    if (mfo[0] > mmax) begin mmax = mfo[0]; mmts = mts; end
                end else begin
                    mvalid = 1; mamp = mmax; mpts = mmts; mtrack = 0;
                end
            end else if (above) begin
                mtrack = 1; mmax = mfo[0]; mmts = mts;
            end
            mprev = above;
        end
        mts = mts + 32'd1;

        if (clear) begin
            for (int i = 0; i < N; i++) hx[i] = 0;
            mp = 0;
            for (int i = 0; i < 3; i++) begin
                ms[i] = 0; mfo[i] = 0; qx[i] = 0;
                for (int j = 0; j < 3; j++) qf[i][j] = 0;
            end
        end else begin
            x = longint'(input_data);
            d = x - hx[K-1] - hx[L-1] + hx[N-1];
            for (int i = N - 1; i > 0; i--) hx[i] = hx[i-1];
            hx[0] = int'(x);
            mp = mp + d;
            xo = qx[0];
            qx[0] = qx[1]; qx[1] = qx[2]; qx[2] = x;
            for (int i = 0; i < 3; i++) begin
                ms[i] = ms[i] + mp + mM[i] * d;
                ff = qf[i][0];
                qf[i][0] = qf[i][1]; qf[i][1] = qf[i][2];
                qf[i][2] = sat(ms[i], mW[i]);
                mfo[i] = bypass ? sat(xo, mW[i]) : ff;
            end
        end
    endtask

    // One clock: update the model, let the edge happen, compare all outputs.
    task automatic applyStimulus();
        modelEdge();
        @(posedge clk);
        #1;
        checkOutput("fo_m0", longint'($signed(fo0)), mfo[0]);
        checkOutput("fo_m1", longint'($signed(fo1)), mfo[1]);
        checkOutput("fo_sat", longint'($signed(fo2)), mfo[2]);
        checkOutput("peak_valid", longint'(pv0), longint'(mvalid));
        checkOutput("lost_cnt", longint'(lc0), longint'(mlost));
        if (mvalid) begin
            checkOutput("peak_amp", longint'($signed(pa0)), mamp);
            checkOutput("peak_ts", longint'(pts0), longint'(mpts));
        end
    endtask

    // Single impulse of 100 with ready high: expect exactly one report of 200.
    task automatic runPeakImpulse(input string tag);
        logic [31:0] e_imp;
        int          pulses;
        threshold  = 24'd150;
        peak_ready = 1'b1;
        input_data = 14'd100;
        applyStimulus();
        e_imp = mts;
        input_data = 14'd0;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            applyStimulus();
            if (pv0) begin
                pulses++;
                checkOutput({tag, "_amp"}, longint'($signed(pa0)), 200);
                checkOutput({tag, "_ts"}, longint'(pts0), longint'(e_imp + 32'd4));
            end
        end
        checkOutput({tag, "_pulses"}, longint'(pulses), 1);
    endtask

    initial begin
        logic [31:0] e_a;

        reset      = 1'b0;
        clear      = 1'b0;
        bypass     = 1'b0;
        input_data = '0;
        threshold  = 24'h7FFFFF;
        peak_ready = 1'b0;
        modelReset();

        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_fo", longint'(fo0), 0);
        checkOutput("rst_fo_m1", longint'(fo1), 0);
        checkOutput("rst_valid", longint'(pv0), 0);
        checkOutput("rst_amp", longint'(pa0), 0);
        checkOutput("rst_ts", longint'(pts0), 0);
        checkOutput("rst_lost", longint'(lc0), 0);
        reset = 1'b1;

        tbl[0] = '{14'd100, 0, 0};
        tbl[1] = '{14'd0, 0, 0};
        tbl[2] = '{14'd0, 0, 0};
        tbl[3] = '{14'd0, 100, 200};
        tbl[4] = '{14'd0, 200, 300};
        tbl[5] = '{14'd0, 200, 200};
        tbl[6] = '{14'd0, 200, 200};
        tbl[7] = '{14'd0, 100, 0};
        tbl[8] = '{14'd0, 0, -100};
        tbl[9] = '{14'd0, 0, 0};
        tbl[10] = '{14'd0, 0, 0};
        tbl[11] = '{14'd0, 0, 0};
        for (int i = 0; i < 12; i++) begin
            input_data = tbl[i].x;
            applyStimulus();
            checkOutput("imp_m0", longint'($signed(fo0)), tbl[i].e0);
            checkOutput("imp_m1", longint'($signed(fo1)), tbl[i].e1);
        end

        runPeakImpulse("hs");

        // Backpressure: first report must be held while the second is dropped.
        peak_ready = 1'b0;
        input_data = 14'd100;
        applyStimulus();
        e_a = mts;
        input_data = 14'd0;
        repeat (19) applyStimulus();
        input_data = 14'd100;
        applyStimulus();
        input_data = 14'd0;
        repeat (20) applyStimulus();
        checkOutput("bp_valid", longint'(pv0), 1);
        checkOutput("bp_amp", longint'($signed(pa0)), 200);
        checkOutput("bp_ts", longint'(pts0), longint'(e_a + 32'd4));
        checkOutput("bp_lost", longint'(lc0), 1);
        peak_ready = 1'b1;
        applyStimulus();
        checkOutput("bp_release", longint'(pv0), 0);

        // Saturation on the 12-bit instance with a full-scale step.
        threshold  = 24'h7FFFFF;
        input_data = 14'h3FFF;
        repeat (12) applyStimulus();
        checkOutput("sat_clamp", longint'($signed(fo2)), 2047);
        checkOutput("sat_wide", longint'($signed(fo0)), 131064);
        applyStimulus();
        checkOutput("sat_hold", longint'($signed(fo2)), 2047);
        input_data = 14'd0;
        repeat (12) applyStimulus();
        checkOutput("sat_back_m0", longint'($signed(fo0)), 0);
        checkOutput("sat_back_w12", longint'($signed(fo2)), 0);

        // Clear mid-pulse: outputs zero next edge, lost_cnt and timestamp kept.
        threshold  = 24'd150;
        input_data = 14'd100;
        applyStimulus();
        input_data = 14'd0;
        repeat (4) applyStimulus();
        clear = 1'b1;
        applyStimulus();
        clear = 1'b0;
        checkOutput("clr_fo", longint'(fo0), 0);
        checkOutput("clr_fo_m1", longint'(fo1), 0);
        checkOutput("clr_valid", longint'(pv0), 0);
        checkOutput("clr_lost", longint'(lc0), 1);
        runPeakImpulse("clr");

        // Asynchronous reset mid-pulse: outputs zero without a clock edge.
        input_data = 14'd100;
        applyStimulus();
        input_data = 14'd0;
        repeat (4) applyStimulus();
        reset = 1'b0;
        #2;
        checkOutput("arst_fo", longint'(fo0), 0);
        checkOutput("arst_fo_m1", longint'(fo1), 0);
        checkOutput("arst_valid", longint'(pv0), 0);
        checkOutput("arst_amp", longint'(pa0), 0);
        checkOutput("arst_ts", longint'(pts0), 0);
        checkOutput("arst_lost", longint'(lc0), 0);
        modelReset();
        #1;
        reset = 1'b1;

        // Randomised traffic against the reference model.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 11) == 0)
                input_data = 14'($urandom_range(0, 3000));
            else if ($urandom_range(0, 199) == 0)
                input_data = 14'h3FFF;
            else
                input_data = 14'd0;
            if (c % 200 == 0) begin
                if ($urandom_range(0, 7) == 0) threshold = 24'(-50);
                else threshold = 24'($urandom_range(0, 4000));
            end
            if (c % 97 == 0) bypass = ($urandom_range(0, 4) == 0);
            clear      = ($urandom_range(0, 299) == 0);
            peak_ready = ($urandom_range(0, 3) == 0);
            applyStimulus();
        end
        clear = 1'b0;

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
